// File: rtl/clk_rst_sequencer.sv
// MMCM reset/lock sequencer with ordered per-domain reset release and relock handling.
// Optional SPI x2 clock-select sequencing is enabled by defining SPI_CLK_SEL_SEQ_EN.
module clk_rst_sequencer #(
  parameter int NUM_DOM      = 4,
  parameter int MMCM_RST_CYC = 16,
  parameter int LOCK_STB_CYC = 1024,
  parameter int LOCK_TO_CYC  = 65535,
  parameter int REL_GAP_CYC  = 8,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               mmcm_locked,
  output logic               mmcm_rst,
  output logic [NUM_DOM-1:0] dom_rst_n,
  output logic               clk_ready,
  output logic               lock_err,
  output logic [7:0]         relock_cnt,
  input  logic               spi_sel_req,
  input  logic               spi_busy,
  output logic               spi_clk_x2_sel,
  output logic               sel_done
);

  typedef enum logic [2:0] {
    MRST  = 3'd0,
    WLOCK = 3'd1,
    STAB  = 3'd2,
    REL   = 3'd3,
    RUN   = 3'd4
  } state_t;

  localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(MMCM_RST_CYC - 1);
  localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(LOCK_STB_CYC - 1);
  localparam logic [CNT_W-1:0]   TO_LAST  = CNT_W'(LOCK_TO_CYC - 1);
  localparam logic [CNT_W-1:0]   GAP_LAST = CNT_W'(REL_GAP_CYC - 1);
  localparam logic [NUM_DOM-1:0] DOM_ONE  = NUM_DOM'(1);

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             lock_s1_r;
  logic             lock_r;

  // Two-flop synchroniser for the asynchronous MMCM lock indication.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lock_s1_r <= 1'b0;
      lock_r    <= 1'b0;
    end else begin
      lock_s1_r <= mmcm_locked;
      lock_r    <= lock_s1_r;
    end
  end

  // Sequencing FSM; the shared counter is cleared on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= MRST;
      cnt_r      <= '0;
      mmcm_rst   <= 1'b1;
      dom_rst_n  <= '0;
      clk_ready  <= 1'b0;
      lock_err   <= 1'b0;
      relock_cnt <= 8'd0;
    end else begin
      case (state_r)
        MRST: begin
          mmcm_rst  <= 1'b1;
          dom_rst_n <= '0;
          clk_ready <= 1'b0;
          if (cnt_r == RST_LAST) begin
            state_r  <= WLOCK;
            cnt_r    <= '0;
            mmcm_rst <= 1'b0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        WLOCK: begin
          if (lock_r) begin
            state_r <= STAB;
            cnt_r   <= '0;
          end else if (cnt_r == TO_LAST) begin
            lock_err <= 1'b1;
            mmcm_rst <= 1'b1;
            state_r  <= MRST;
            cnt_r    <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        STAB: begin
          if (!lock_r) begin
            state_r <= WLOCK;
            cnt_r   <= '0;
          end else if (cnt_r == STB_LAST) begin
            state_r   <= REL;
            cnt_r     <= '0;
            dom_rst_n <= DOM_ONE;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        REL, RUN: begin
          // A lock drop while releasing or running forces a full resequence.
          if (!lock_r) begin
            relock_cnt <= (relock_cnt == 8'hFF) ? 8'hFF : relock_cnt + 8'd1;
            dom_rst_n  <= '0;
            clk_ready  <= 1'b0;
            mmcm_rst   <= 1'b1;
            state_r    <= MRST;
            cnt_r      <= '0;
          end else if (state_r == RUN) begin
            clk_ready <= 1'b1;
          end else if (&dom_rst_n) begin
            state_r   <= RUN;
            cnt_r     <= '0;
            clk_ready <= 1'b1;
          end else if (cnt_r == GAP_LAST) begin
            dom_rst_n <= (dom_rst_n << 1'b1) | DOM_ONE;
            cnt_r     <= '0;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        default: begin
          state_r   <= MRST;
          cnt_r     <= '0;
          mmcm_rst  <= 1'b1;
          dom_rst_n <= '0;
          clk_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef SPI_CLK_SEL_SEQ_EN
  logic qual_r;

  // Select switches only in RUN, after two consecutive idle cycles with a differing request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi_clk_x2_sel <= 1'b0;
      sel_done       <= 1'b0;
      qual_r         <= 1'b0;
    end else begin
      sel_done <= 1'b0;
      if ((state_r != RUN) || !lock_r) begin
        spi_clk_x2_sel <= 1'b0;
        qual_r         <= 1'b0;
      end else if ((spi_sel_req != spi_clk_x2_sel) && !spi_busy) begin
        if (qual_r) begin
          spi_clk_x2_sel <= spi_sel_req;
          sel_done       <= 1'b1;
          qual_r         <= 1'b0;
        end else begin
          qual_r <= 1'b1;
        end
      end else begin
        qual_r <= 1'b0;
      end
    end
  end
`else
  logic unused_spi;
  assign unused_spi     = ^{spi_sel_req, spi_busy};
  assign spi_clk_x2_sel = 1'b0;
  assign sel_done       = 1'b0;
`endif

endmodule
